// File: rtl/split_mlp_shared_bram_sequencer_pkg.sv
// Shared types and width helpers for the split-MLP job sequencer.
package split_mlp_seq_pkg;

  localparam int SEQ_A_W   = 9;
  localparam int SEQ_B_W   = 9;
  localparam int SEQ_LEN_W = 10;

  typedef enum logic [1:0] {IDLE, RUN, CLEAR} seq_state_t;

  typedef struct packed {
    logic [SEQ_A_W-1:0]   a_base;
    logic [SEQ_B_W-1:0]   b_base;
    logic [SEQ_LEN_W-1:0] len;
  } seq_cmd_t;

  // Bits needed to hold the values 0..n.
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/split_mlp_shared_bram_sequencer_if.sv
// Command, compute-control, result-FIFO and status signals of the sequencer.
interface split_mlp_shared_bram_sequencer_if #(
  parameter int BRAM_A_RDADDR_WIDTH = split_mlp_seq_pkg::SEQ_A_W,
  parameter int BRAM_B_RDADDR_WIDTH = split_mlp_seq_pkg::SEQ_B_W,
  parameter int LEN_WIDTH           = split_mlp_seq_pkg::SEQ_LEN_W,
  parameter int MAX_OUTSTANDING     = 4
);
  localparam int OUT_W = split_mlp_seq_pkg::cnt_w(MAX_OUTSTANDING);

  logic                           i_cmd_valid;
  logic                           o_cmd_ready;
  logic [BRAM_A_RDADDR_WIDTH-1:0] i_cmd_a_base;
  logic [BRAM_B_RDADDR_WIDTH-1:0] i_cmd_b_base;
  logic [LEN_WIDTH-1:0]           i_cmd_len;
  logic                           i_stall;
  logic                           i_clear;
  logic [BRAM_A_RDADDR_WIDTH-1:0] o_bram_a_rdaddr;
  logic [BRAM_B_RDADDR_WIDTH-1:0] o_bram_b_rdaddr;
  logic                           o_first;
  logic                           o_pause;
  logic                           o_last;
  logic                           i_result_empty;
  logic                           i_result_almost_full;
  logic                           i_drain_ready;
  logic                           o_result_rden;
  logic                           o_result_rstn;
  logic                           i_result_valid;
  logic                           o_busy;
  logic [OUT_W-1:0]               o_outstanding;
  logic                           o_job_done;
  logic                           o_cmd_err;

  modport master (
    output i_cmd_valid, i_cmd_a_base, i_cmd_b_base, i_cmd_len, i_stall, i_clear,
           i_result_empty, i_result_almost_full, i_drain_ready, i_result_valid,
    input  o_cmd_ready, o_bram_a_rdaddr, o_bram_b_rdaddr, o_first, o_pause, o_last,
           o_result_rden, o_result_rstn, o_busy, o_outstanding, o_job_done, o_cmd_err
  );

  modport slave (
    input  i_cmd_valid, i_cmd_a_base, i_cmd_b_base, i_cmd_len, i_stall, i_clear,
           i_result_empty, i_result_almost_full, i_drain_ready, i_result_valid,
    output o_cmd_ready, o_bram_a_rdaddr, o_bram_b_rdaddr, o_first, o_pause, o_last,
           o_result_rden, o_result_rstn, o_busy, o_outstanding, o_job_done, o_cmd_err
  );

endinterface

// File: rtl/split_mlp_shared_bram_sequencer_drain.sv
// Result-side bookkeeping: outstanding jobs, paced FIFO reads, per-job result count.
module split_mlp_result_drain
  import split_mlp_seq_pkg::*;
#(
  parameter int NUM_GROUPS      = 4,
  parameter int MAX_OUTSTANDING = 4,
  parameter int DRAIN_GAP       = 4,
  localparam int OUT_W          = cnt_w(MAX_OUTSTANDING)
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_last_beat,
  input  logic             i_clear,
  input  logic             i_in_clear,
  input  logic             i_result_empty,
  input  logic             i_drain_ready,
  input  logic             i_result_valid,
  output logic             o_result_rden,
  output logic [OUT_W-1:0] o_outstanding,
  output logic             o_job_done
);
  localparam int GAP_W = cnt_w(DRAIN_GAP);
  localparam int RES_W = cnt_w(2 * NUM_GROUPS - 1);

  logic [OUT_W-1:0] out_q, out_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [RES_W-1:0] res_q, res_d;
  logic             rden_q, rden_d;
  logic             done_q, done_d;

  always_comb begin
    rden_d = (out_q != '0) && !i_result_empty && i_drain_ready &&
             (gap_q >= GAP_W'(DRAIN_GAP)) && !i_clear && !i_in_clear;
    // gap_q saturates at DRAIN_GAP so an idle FIFO is read as soon as it fills.
    gap_d  = rden_d ? GAP_W'(1) :
             (gap_q < GAP_W'(DRAIN_GAP)) ? gap_q + GAP_W'(1) : gap_q;
    out_d  = out_q;
    case ({i_last_beat, rden_d})
      2'b10:   if (out_q != OUT_W'(MAX_OUTSTANDING)) out_d = out_q + OUT_W'(1);
      2'b01:   out_d = out_q - OUT_W'(1);
      default: out_d = out_q;
    endcase
    res_d  = res_q;
    done_d = 1'b0;
    if (i_clear) begin
      out_d = '0;
      res_d = '0;
    end else if (!i_in_clear && i_result_valid) begin
      if (res_q == RES_W'(2 * NUM_GROUPS - 1)) begin
        res_d  = '0;
        done_d = 1'b1;
      end else begin
        res_d = res_q + RES_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      out_q  <= '0;
      gap_q  <= GAP_W'(DRAIN_GAP);
      res_q  <= '0;
      rden_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      out_q  <= out_d;
      gap_q  <= gap_d;
      res_q  <= res_d;
      rden_q <= rden_d;
      done_q <= done_d;
    end
  end

  assign o_result_rden = rden_q;
  assign o_outstanding = out_q;
  assign o_job_done    = done_q;

endmodule

// File: rtl/split_mlp_shared_bram_sequencer.sv
// Job sequencer: accepts dot-product jobs and walks A/B read addresses with first/pause/last.
module split_mlp_shared_bram_sequencer
  import split_mlp_seq_pkg::*;
#(
  parameter int NUM_GROUPS          = 4,
  parameter int BRAM_A_RDADDR_WIDTH = SEQ_A_W,
  parameter int BRAM_B_RDADDR_WIDTH = SEQ_B_W,
  parameter int LEN_WIDTH           = SEQ_LEN_W,
  parameter int MAX_OUTSTANDING     = 4,
  parameter int DRAIN_GAP           = 4,
  parameter int CLEAR_CYCLES        = 4
) (
  input  logic i_clk,
  input  logic i_rstn,
  split_mlp_shared_bram_sequencer_if.slave bus
);
  localparam int CLR_W = cnt_w(CLEAR_CYCLES);
  localparam int OUT_W = cnt_w(MAX_OUTSTANDING);

  seq_state_t                     state_q, state_d;
  seq_cmd_t                       cmd_q, cmd_d;
  logic [LEN_WIDTH-1:0]           k_q, k_d;
  logic [BRAM_A_RDADDR_WIDTH-1:0] a_q, a_d;
  logic [BRAM_B_RDADDR_WIDTH-1:0] b_q, b_d;
  logic                           first_q, first_d, pause_q, pause_d, last_q, last_d;
  logic                           err_q, err_d, busy_q, busy_d;
  logic                           rstn_q, rstn_d, por_q, por_d;
  logic [CLR_W-1:0]               clr_cnt_q, clr_cnt_d;
  logic [OUT_W-1:0]               outstanding;
  logic                           accept;

  assign bus.o_cmd_ready = (state_q == IDLE) && (outstanding < OUT_W'(MAX_OUTSTANDING)) &&
                           !bus.i_result_almost_full && rstn_q && !bus.i_clear;
  assign accept = bus.i_cmd_valid && bus.o_cmd_ready;

  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    k_d       = k_q;
    a_d       = a_q;
    b_d       = b_q;
    first_d   = 1'b0;
    pause_d   = 1'b0;
    last_d    = 1'b0;
    err_d     = 1'b0;
    por_d     = 1'b1;
    // FIFO reset releases one edge after por_q, i.e. on the 2nd edge out of reset.
    rstn_d    = por_q;
    clr_cnt_d = clr_cnt_q;
    if (bus.i_clear) begin
      state_d   = CLEAR;
      clr_cnt_d = '0;
      rstn_d    = 1'b0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          if (bus.i_cmd_len == '0) begin
            err_d = 1'b1;
          end else begin
            state_d = RUN;
            cmd_d   = '{a_base: bus.i_cmd_a_base, b_base: bus.i_cmd_b_base, len: bus.i_cmd_len};
            k_d     = '0;
          end
        end
        RUN: if (bus.i_stall) begin
          pause_d = 1'b1;
        end else begin
          a_d     = cmd_q.a_base + BRAM_A_RDADDR_WIDTH'(k_q);
          b_d     = cmd_q.b_base + BRAM_B_RDADDR_WIDTH'(k_q);
          first_d = (k_q == '0);
          last_d  = (k_q == cmd_q.len - LEN_WIDTH'(1));
          k_d     = k_q + LEN_WIDTH'(1);
          if (last_d) state_d = IDLE;
        end
        CLEAR: begin
          rstn_d = 1'b0;
          if (clr_cnt_q == CLR_W'(CLEAR_CYCLES - 1)) begin
            state_d = IDLE;
            rstn_d  = por_q;
          end else begin
            clr_cnt_d = clr_cnt_q + CLR_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q   <= IDLE;
      cmd_q     <= '0;
      k_q       <= '0;
      a_q       <= '0;
      b_q       <= '0;
      first_q   <= 1'b0;
      pause_q   <= 1'b0;
      last_q    <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      rstn_q    <= 1'b0;
      por_q     <= 1'b0;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      k_q       <= k_d;
      a_q       <= a_d;
      b_q       <= b_d;
      first_q   <= first_d;
      pause_q   <= pause_d;
      last_q    <= last_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      rstn_q    <= rstn_d;
      por_q     <= por_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  split_mlp_result_drain #(
    .NUM_GROUPS      (NUM_GROUPS),
    .MAX_OUTSTANDING (MAX_OUTSTANDING),
    .DRAIN_GAP       (DRAIN_GAP)
  ) u_drain (
    .i_clk          (i_clk),
    .i_rstn         (i_rstn),
    .i_last_beat    (last_d),
    .i_clear        (bus.i_clear),
    .i_in_clear     (state_q == CLEAR),
    .i_result_empty (bus.i_result_empty),
    .i_drain_ready  (bus.i_drain_ready),
    .i_result_valid (bus.i_result_valid),
    .o_result_rden  (bus.o_result_rden),
    .o_outstanding  (outstanding),
    .o_job_done     (bus.o_job_done)
  );

  assign bus.o_bram_a_rdaddr = a_q;
  assign bus.o_bram_b_rdaddr = b_q;
  assign bus.o_first         = first_q;
  assign bus.o_pause         = pause_q;
  assign bus.o_last          = last_q;
  assign bus.o_result_rstn   = rstn_q;
  assign bus.o_busy          = busy_q;
  assign bus.o_outstanding   = outstanding;
  assign bus.o_cmd_err       = err_q;

endmodule

// File: tb/tb_split_mlp_shared_bram_sequencer.sv
// Directed bench for the job sequencer: job-level reference model checked every cycle plus literal anchors.
module tb_split_mlp_shared_bram_sequencer;
  typedef struct { int a; int b; bit f; bit l; } beat_t;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   n_cmp = 0, n_bad = 0, cyc = 0;

  split_mlp_shared_bram_sequencer_if bus ();
  split_mlp_shared_bram_sequencer dut (.i_clk(clk), .i_rstn(rstn), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: no response within cycle budget (cycle %0d)", name, cyc);
  endtask

  // Reference model: job state 0=idle 1=run 2=clear, tracked as plain integers.
  int  m_state, m_ab, m_bb, m_len, m_k, m_out, m_gap, m_rcnt, m_left;
  bit  m_por;
  int  e_a, e_b;
  bit  e_first, e_last, e_pause, e_rden, e_done, e_err, e_rstn, e_beat;

  function automatic bit model_ready();
    return m_state == 0 && m_out < 4 && !bus.i_result_almost_full && e_rstn && !bus.i_clear;
  endfunction

  task automatic model_reset();
    m_state = 0; m_ab = 0; m_bb = 0; m_len = 0; m_k = 0; m_out = 0;
    m_gap = 4; m_rcnt = 0; m_left = 0; m_por = 0; e_a = 0; e_b = 0;
    {e_first, e_last, e_pause, e_rden, e_done, e_err, e_rstn, e_beat} = '0;
  endtask

  task automatic model_step();
    bit rdy, rd, in_clr;
    rdy    = model_ready();
    in_clr = (m_state == 2);
    rd     = m_out != 0 && !bus.i_result_empty && bus.i_drain_ready && m_gap >= 4 &&
             !in_clr && !bus.i_clear;
    {e_first, e_last, e_pause, e_err, e_done, e_beat} = '0;
    e_rden = rd;
    if (bus.i_clear) begin
      m_state = 2; m_left = 4; e_rstn = 0; m_out = 0; m_rcnt = 0;
    end else begin
      if (!in_clr) e_rstn = m_por;
      if (m_state == 0 && bus.i_cmd_valid && rdy) begin
        if (bus.i_cmd_len == 0) e_err = 1;
        else begin
          m_state = 1; m_k = 0;
          m_ab = int'(bus.i_cmd_a_base); m_bb = int'(bus.i_cmd_b_base); m_len = int'(bus.i_cmd_len);
        end
      end else if (m_state == 1) begin
        if (bus.i_stall) e_pause = 1;
        else begin
          e_beat  = 1;
          e_a     = (m_ab + m_k) % 512;
          e_b     = (m_bb + m_k) % 512;
          e_first = (m_k == 0);
          e_last  = (m_k == m_len - 1);
          m_k++;
          if (e_last) begin m_state = 0; m_out++; end
        end
      end else if (m_state == 2) begin
        m_left--;
        if (m_left == 0) begin m_state = 0; e_rstn = 1; end
      end
      if (!in_clr && bus.i_result_valid) begin
        m_rcnt++;
        if (m_rcnt == 8) begin m_rcnt = 0; e_done = 1; end
      end
    end
    if (rd) begin m_out--; m_gap = 1; end
    else if (m_gap < 4) m_gap++;
    m_por = 1;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rstn);
      if (!rstn) model_reset();
      else model_step();
    end
  end

  // Per-cycle compare plus event logs for the directed checks.
  beat_t beats[$];
  int    rden_cyc[$], rden_out[$];
  int    n_pause, n_last, n_done, done_cyc, n_err, n_busy, n_rlow;

  task automatic clear_logs();
    beats.delete(); rden_cyc.delete(); rden_out.delete();
    n_pause = 0; n_last = 0; n_done = 0; done_cyc = -1; n_err = 0; n_busy = 0; n_rlow = 0;
  endtask

  initial forever begin
    @(negedge clk);
    check("cmd_ready", int'(bus.o_cmd_ready), int'(model_ready()));
    check("first/last/pause", int'({bus.o_first, bus.o_last, bus.o_pause}),
          int'({e_first, e_last, e_pause}));
    if (e_beat)
      check("A/B rdaddr", int'({bus.o_bram_a_rdaddr, bus.o_bram_b_rdaddr}), int'({9'(e_a), 9'(e_b)}));
    check("rden/rstn", int'({bus.o_result_rden, bus.o_result_rstn}), int'({e_rden, e_rstn}));
    check("busy/outstanding/done/err",
          int'({bus.o_busy, bus.o_outstanding, bus.o_job_done, bus.o_cmd_err}),
          int'({m_state != 0, 3'(m_out), e_done, e_err}));
    if (e_beat) beats.push_back('{int'(bus.o_bram_a_rdaddr), int'(bus.o_bram_b_rdaddr), bus.o_first, bus.o_last});
    if (bus.o_result_rden) begin rden_cyc.push_back(cyc); rden_out.push_back(int'(bus.o_outstanding)); end
    if (bus.o_pause) n_pause++;
    if (bus.o_last) n_last++;
    if (bus.o_job_done) begin n_done++; done_cyc = cyc; end
    if (bus.o_cmd_err) n_err++;
    if (bus.o_busy) n_busy++;
    if (!bus.o_result_rstn) n_rlow++;
  end

  task automatic cyc_wait(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input int a, input int b, input int len);
    bus.i_cmd_a_base = 9'(a);
    bus.i_cmd_b_base = 9'(b);
    bus.i_cmd_len    = 10'(len);
    bus.i_cmd_valid  = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.o_cmd_ready) begin
        @(posedge clk);
        #1;
        bus.i_cmd_valid = 1'b0;
        return;
      end
    end
    bus.i_cmd_valid = 1'b0;
    timeout("cmd accept");
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!bus.o_busy) begin cyc_wait(2); return; end
    end
    timeout("job completion");
  endtask

  // Returns the cycle in which the last valid was presented.
  task automatic feed_valids(input int n, output int last_cyc);
    last_cyc = -1;
    for (int i = 0; i < n; i++) begin
      bus.i_result_valid = 1'b1;
      last_cyc = cyc;
      cyc_wait(1);
      bus.i_result_valid = 1'b0;
      cyc_wait(1 + i % 2);
    end
  endtask

  initial begin
    int vc;
    int ea1[3] = '{'h010, 'h011, 'h012};
    int eb1[3] = '{'h020, 'h021, 'h022};
    int ea3[4] = '{'h1FE, 'h1FF, 'h000, 'h001};
    bus.i_cmd_valid = 0; bus.i_cmd_a_base = '0; bus.i_cmd_b_base = '0; bus.i_cmd_len = '0;
    bus.i_stall = 0; bus.i_clear = 0; bus.i_result_empty = 1; bus.i_result_almost_full = 0;
    bus.i_drain_ready = 0; bus.i_result_valid = 0;
    clear_logs();

    repeat (3) @(posedge clk);
    #1;
    check("reset outputs", int'({bus.o_cmd_ready, bus.o_first, bus.o_pause, bus.o_last, bus.o_result_rden,
          bus.o_result_rstn, bus.o_busy, bus.o_outstanding, bus.o_job_done, bus.o_cmd_err,
          bus.o_bram_a_rdaddr, bus.o_bram_b_rdaddr}), 0);
    rstn = 1'b1;
    cyc_wait(1);
    check("rstn after 1st edge", int'({bus.o_result_rstn, bus.o_cmd_ready}), 0);
    cyc_wait(1);
    check("rstn after 2nd edge", int'(bus.o_result_rstn), 1);

    // Basic job
    clear_logs();
    send('h010, 'h020, 3);
    wait_idle();
    check("t1 beat count", beats.size(), 3);
    for (int i = 0; i < 3; i++) if (i < beats.size()) begin
      check("t1 A addr", beats[i].a, ea1[i]);
      check("t1 B addr", beats[i].b, eb1[i]);
      check("t1 first/last", int'({beats[i].f, beats[i].l}), (i == 0) ? 2 : (i == 2) ? 1 : 0);
    end
    check("t1 outstanding", int'(bus.o_outstanding), 1);

    // len=1 with two stall cycles
    clear_logs();
    send('h100, 'h040, 1);
    bus.i_stall = 1'b1;
    cyc_wait(2);
    bus.i_stall = 1'b0;
    wait_idle();
    check("t2 pause beats", n_pause, 2);
    check("t2 beat count", beats.size(), 1);
    if (beats.size() == 1) check("t2 first&last", int'({beats[0].f, beats[0].l}), 3);

    // Address wrap
    clear_logs();
    send('h1FE, 'h005, 4);
    wait_idle();
    check("t3 beat count", beats.size(), 4);
    for (int i = 0; i < 4; i++) if (i < beats.size()) check("t3 A wrap", beats[i].a, ea3[i]);

    // Fourth outstanding job blocks commands, then paced drain
    send('h000, 'h000, 2);
    wait_idle();
    @(negedge clk);
    check("t4 full outstanding", int'(bus.o_outstanding), 4);
    check("t4 ready blocked", int'(bus.o_cmd_ready), 0);
    cyc_wait(1);
    clear_logs();
    bus.i_result_empty = 1'b0;
    bus.i_drain_ready  = 1'b1;
    for (int i = 0; i < 100 && bus.o_outstanding != 0; i++) @(negedge clk);
    cyc_wait(2);
    bus.i_result_empty = 1'b1;
    bus.i_drain_ready  = 1'b0;
    check("t4 drained", int'(bus.o_outstanding), 0);
    check("t4 rden count", rden_cyc.size(), 4);
    for (int i = 1; i < rden_cyc.size(); i++) check("t4 rden spacing", rden_cyc[i] - rden_cyc[i-1], 4);
    if (rden_out.size() > 0) check("t4 outstanding at final rden", rden_out[rden_out.size()-1], 0);

    // Result counting
    clear_logs();
    feed_valids(8, vc);
    cyc_wait(3);
    check("t5 job_done count", n_done, 1);
    check("t5 job_done timing", done_cyc, vc + 1);

    // Clear mid-job with one job outstanding and a partial result count
    send('h000, 'h000, 2);
    wait_idle();
    feed_valids(3, vc);
    clear_logs();
    send('h050, 'h060, 10);
    cyc_wait(5);
    bus.i_clear = 1'b1;
    cyc_wait(1);
    bus.i_clear = 1'b0;
    cyc_wait(8);
    check("t6 beats before clear", beats.size(), 5);
    check("t6 no last", n_last, 0);
    check("t6 rstn low cycles", n_rlow, 4);
    check("t6 outstanding", int'(bus.o_outstanding), 0);
    check("t6 busy", int'(bus.o_busy), 0);
    feed_valids(8, vc);
    cyc_wait(3);
    check("t6 job_done after clear", n_done, 1);
    check("t6 job_done timing", done_cyc, vc + 1);

    // Zero-length command
    clear_logs();
    send('h033, 'h044, 0);
    cyc_wait(3);
    check("t7 cmd_err pulses", n_err, 1);
    check("t7 busy cycles", n_busy, 0);

    // Async reset mid-job
    clear_logs();
    send('h020, 'h030, 6);
    cyc_wait(2);
    #2 rstn = 1'b0;
    #1;
    check("t8 async reset outputs", int'({bus.o_cmd_ready, bus.o_first, bus.o_pause, bus.o_last,
          bus.o_result_rden, bus.o_result_rstn, bus.o_busy, bus.o_outstanding, bus.o_job_done,
          bus.o_cmd_err}), 0);
    cyc_wait(2);
    rstn = 1'b1;
    cyc_wait(3);
    check("t8 no last", n_last, 0);
    clear_logs();
    send('h0AA, 'h0BB, 2);
    wait_idle();
    check("t8 job after reset", beats.size(), 2);
    if (beats.size() == 2) check("t8 A addr", beats[1].a, 'h0AB);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
